// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state, direction and floor constants for the SCAN elevator
package elevator_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int FLOOR_NONE = 0;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable down-counter that holds at zero and flags it
module elevator_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (!zero) count <= count - 1'b1;
    end
    assign zero = count == '0;
endmodule

// File: rtl/elevator_scan.sv
// elevator_scan: single-car SCAN elevator with pending-call bitmap, travel and door timing
module elevator_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = 7,
    parameter int FLOOR_W = 3,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] from,
    output logic               out,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               direction,
    output logic [FLOORS-1:0]  request,
    output logic               busy
);
    localparam int TMAX = max2(MOVE_CYCLES, DOOR_CYCLES);
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    state_t state;
    logic [FLOORS-1:0] above, below, cur_mask, nf_mask, call_mask, clr_mask;
    logic [FLOOR_W-1:0] nf;
    logic here, hit, ahead, behind, zero, load, go_door;
    logic [TW-1:0] load_val;
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above[i] = (i + 1) > int'(cur_floor);
            below[i] = (i + 1) < int'(cur_floor);
        end
    end
    assign ahead = |(request & (direction ? above : below));
    assign behind = |(request & (direction ? below : above));
    assign nf = direction ? cur_floor + 1'b1 : cur_floor - 1'b1;
    assign cur_mask = FLOORS'(1) << (cur_floor - 1'b1);
    assign nf_mask = FLOORS'(1) << (nf - 1'b1);
    assign call_mask = (from != FLOOR_W'(FLOOR_NONE) && from <= FLOOR_W'(FLOORS))
                       ? FLOORS'(1) << (from - 1'b1) : '0;
    assign here = |(request & cur_mask);
    assign hit = |(request & nf_mask);
    assign go_door = (state == IDLE && here) || (state == MOVE && zero && hit);
    assign load = (state == IDLE && (here || ahead || behind)) || (state == MOVE && zero);
    assign load_val = go_door ? TW'(DOOR_CYCLES - 1) : TW'(MOVE_CYCLES - 1);
    // a clear on the same edge as a call wins, so door-open absorbs calls for this floor
    assign clr_mask = state == MOVE ? (go_door ? nf_mask : '0)
                    : (state == DOOR || here) ? cur_mask : '0;
    assign out = state == DOOR;
    assign busy = state != IDLE;
    elevator_timer #(.W(TW)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .zero(zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cur_floor <= FLOOR_W'(1);
            direction <= DIR_UP;
            request <= '0;
        end else begin
            request <= (request | call_mask) & ~clr_mask;
            if (state == IDLE) begin
                if (here) state <= DOOR;
                else if (ahead) state <= MOVE;
                else if (behind) begin
                    state <= MOVE;
                    direction <= direction == DIR_UP ? DIR_DOWN : DIR_UP;
                end
            end else if (state == MOVE) begin
                if (zero) begin
                    cur_floor <= nf;
                    if (hit) state <= DOOR;
                end
            end else if (zero) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_elevator_scan.sv
// tb_elevator_scan: directed and random checks of elevator_scan against a floor-level model
module tb_elevator_scan;
    localparam int FL = 7;
    localparam int MC = 2;
    localparam int DC = 3;
    localparam logic [12:0] RESET_VEC = 13'b0_001_1_0000000_0;
    logic clk = 0, reset = 0;
    logic [2:0] from = 0, from5 = 0;
    logic out, direction, busy, out5, dir5, busy5;
    logic [2:0] cur_floor, cur5;
    logic [6:0] request;
    logic [4:0] req5;
    logic [12:0] dut_vec;
    int n_checks = 0, n_fail = 0;
    int m_floor, mode, cnt;
    bit m_dir;
    bit pend [1:FL];

    elevator_scan dut (
        .clk(clk), .reset(reset), .from(from), .out(out), .cur_floor(cur_floor),
        .direction(direction), .request(request), .busy(busy)
    );
    elevator_scan #(.FLOORS(5)) dut5 (
        .clk(clk), .reset(reset), .from(from5), .out(out5), .cur_floor(cur5),
        .direction(dir5), .request(req5), .busy(busy5)
    );

    always #5 clk = ~clk;
    assign dut_vec = {out, cur_floor, direction, request, busy};

    function automatic void model_reset();
        m_floor = 1; m_dir = 1; mode = 0; cnt = 0;
        for (int i = 1; i <= FL; i++) pend[i] = 0;
    endfunction

    // mode: 0 idle, 1 travelling, 2 door open; cnt counts edges left in the current phase
    function automatic void model_step(input int f);
        bit old [1:FL];
        bit up = 0, dn = 0;
        old = pend;
        for (int i = 1; i <= FL; i++) begin
            if (old[i] && i > m_floor) up = 1;
            if (old[i] && i < m_floor) dn = 1;
        end
        if (f >= 1 && f <= FL) pend[f] = 1;
        if (mode == 0) begin
            if (old[m_floor]) begin mode = 2; cnt = DC; pend[m_floor] = 0; end
            else if (m_dir ? up : dn) begin mode = 1; cnt = MC; end
            else if (m_dir ? dn : up) begin m_dir = !m_dir; mode = 1; cnt = MC; end
        end else if (mode == 1) begin
            cnt--;
            if (cnt == 0) begin
                m_floor += m_dir ? 1 : -1;
                if (old[m_floor]) begin mode = 2; cnt = DC; pend[m_floor] = 0; end
                else cnt = MC;
            end
        end else begin
            pend[m_floor] = 0;
            cnt--;
            if (cnt == 0) mode = 0;
        end
    endfunction

    function automatic logic [12:0] model_vec();
        logic [6:0] r;
        for (int i = 1; i <= FL; i++) r[i-1] = pend[i];
        return {mode == 2, 3'(m_floor), m_dir, r, mode != 0};
    endfunction

    task automatic tick(input int f, input bit r);
        reset = r;
        from = 3'(f);
        @(posedge clk);
        #1;
        if (r) model_reset(); else model_step(f);
        reset = 0;
        from = 0;
    endtask

    task automatic test_reset();
        tick(0, 1);
        n_checks++;
        if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL reset: got %b expected %b", dut_vec, RESET_VEC); end
        for (int c = 0; c < 5; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", dut_vec, RESET_VEC); end
        end
    endtask

    task automatic test_call_here();
        int opens = 0;
        tick(1, 0);
        n_checks++;
        if (request !== 7'b0000001 || out !== 1'b0) begin n_fail++; $display("FAIL call_here_latch: got req=%b out=%b expected req=0000001 out=0", request, out); end
        for (int c = 0; c < 6; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL call_here_model: got %b expected %b", dut_vec, model_vec()); end
            if (out) opens++;
        end
        n_checks++;
        if (opens !== 3 || cur_floor !== 3'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL call_here_door: got opens=%0d floor=%0d busy=%b expected 3 1 0", opens, cur_floor, busy); end
    endtask

    task automatic test_single_trip();
        tick(5, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL trip_model k=%0d: got %b expected %b", k, dut_vec, model_vec()); end
            n_checks++;
            if (cur_floor !== 3'(k <= 9 ? 1 + (k - 1) / 2 : 5) || out !== (k >= 9 && k <= 11) || direction !== 1'b1)
                begin n_fail++; $display("FAIL trip_timing k=%0d: got floor=%0d out=%b dir=%b", k, cur_floor, out, direction); end
        end
        n_checks++;
        if (request !== 7'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL trip_end: got req=%b busy=%b expected 0 0", request, busy); end
    endtask

    task automatic test_scan_reversal();
        bit ok = 0, saw7 = 0;
        tick(0, 1);
        tick(7, 0);
        for (int c = 0; c < 30 && !ok; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL scan_up_model: got %b expected %b", dut_vec, model_vec()); end
            ok = cur_floor == 3'd4;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL scan_reach4: got floor=%0d expected 4", cur_floor); end
        tick(3, 0);
        ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL scan_model: got %b expected %b", dut_vec, model_vec()); end
            if (out && cur_floor == 3'd7) begin
                saw7 = 1;
                n_checks++;
                if (direction !== 1'b1) begin n_fail++; $display("FAIL scan_dir_at7: got %b expected 1", direction); end
            end
            ok = cur_floor == 3'd3 && !busy;
        end
        n_checks++;
        if (!ok || !saw7 || direction !== 1'b0 || request !== 7'b0)
            begin n_fail++; $display("FAIL scan_end: got done=%b saw7=%b dir=%b req=%b expected 1 1 0 0", ok, saw7, direction, request); end
    endtask

    task automatic test_absorb_and_reset();
        bit ok = 0;
        int opens = 1;
        tick(5, 0);
        for (int c = 0; c < 20 && !ok; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL absorb_travel: got %b expected %b", dut_vec, model_vec()); end
            ok = out;
        end
        n_checks++;
        if (!ok || cur_floor !== 3'd5) begin n_fail++; $display("FAIL absorb_arrive: got out=%b floor=%0d expected 1 5", out, cur_floor); end
        tick(5, 0);
        if (out) opens++;
        for (int c = 0; c < 5; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL absorb_model: got %b expected %b", dut_vec, model_vec()); end
            if (out) opens++;
        end
        n_checks++;
        if (opens !== 3 || request !== 7'b0) begin n_fail++; $display("FAIL absorb_door: got opens=%0d req=%b expected 3 0", opens, request); end
        tick(1, 0);
        tick(6, 0);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick(0, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL midrun_model: got %b expected %b", dut_vec, model_vec()); end
            ok = cur_floor == 3'd3 && busy && !out;
        end
        n_checks++;
        if (!ok || request !== 7'b0100001) begin n_fail++; $display("FAIL midrun_setup: got floor=%0d req=%b expected 3 0100001", cur_floor, request); end
        tick(0, 1);
        n_checks++;
        if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL midrun_reset: got %b expected %b", dut_vec, RESET_VEC); end
    endtask

    task automatic test_out_of_range();
        for (int v = 6; v <= 7; v++) begin
            from5 = 3'(v);
            @(posedge clk);
            #1;
            from5 = 0;
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if (req5 !== 5'b0 || busy5 !== 1'b0 || cur5 !== 3'd1) begin n_fail++; $display("FAIL out_of_range %0d: got req=%b busy=%b floor=%0d expected 00000 0 1", v, req5, busy5, cur5); end
        end
        from5 = 3'd5;
        @(posedge clk);
        #1;
        from5 = 0;
        n_checks++;
        if (req5 !== 5'b10000) begin n_fail++; $display("FAIL in_range5: got req=%b expected 10000", req5); end
    endtask

    task automatic test_random();
        tick(0, 1);
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(0, 3) == 0 ? int'($urandom_range(1, FL)) : 0, $urandom_range(0, 199) == 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL random c=%0d: got %b expected %b", c, dut_vec, model_vec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_call_here();
        test_single_trip();
        test_scan_reversal();
        test_absorb_and_reset();
        test_out_of_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
